// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core. It also detects load-use hazards,
// injects bubbles on a stall or a branch flush, and keeps saturating debug event counters.
module id_ex_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  input  logic [1:0]    id_wb,
  input  logic [2:0]    id_m,
  input  logic [3:0]    id_exe,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc4,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  output logic [1:0]    ex_wb,
  output logic [2:0]    ex_m,
  output logic [3:0]    ex_exe,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic          ex_valid,
  output logic          stall,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  logic [1:0]    ex_wb_q, ex_wb_d;
  logic [2:0]    ex_m_q, ex_m_d;
  logic [3:0]    ex_exe_q, ex_exe_d;
  logic [DW-1:0] ex_rd1_q, ex_rd1_d, ex_rd2_q, ex_rd2_d;
  logic [DW-1:0] ex_imm_q, ex_imm_d, ex_pc4_q, ex_pc4_d;
  logic [4:0]    ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
  logic          ex_valid_q, ex_valid_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic          rt_used, hazard;

  // Instructions that read rt as a source: R-type, store, branch.
  assign rt_used = id_exe[0] | id_m[2] | id_m[0];
  assign hazard  = ex_valid_q & ex_m_q[1] & (ex_rt_q != 5'd0) &
                   ((ex_rt_q == id_rs) | (rt_used & (ex_rt_q == id_rt)));
  assign stall   = hazard & ~flush & ~hold;

  always_comb begin
    ex_wb_d     = ex_wb_q;
    ex_m_d      = ex_m_q;
    ex_exe_d    = ex_exe_q;
    ex_rd1_d    = ex_rd1_q;
    ex_rd2_d    = ex_rd2_q;
    ex_imm_d    = ex_imm_q;
    ex_pc4_d    = ex_pc4_q;
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_rd_d     = ex_rd_q;
    ex_valid_d  = ex_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold) begin
      ex_rd1_d = id_rd1;
      ex_rd2_d = id_rd2;
      ex_imm_d = id_imm;
      ex_pc4_d = id_pc4;
      ex_rs_d  = id_rs;
      ex_rt_d  = id_rt;
      ex_rd_d  = id_rd;
      if (flush || hazard) begin
        // Bubble: controls forced to zero regardless of the ID control inputs.
        ex_wb_d    = '0;
        ex_m_d     = '0;
        ex_exe_d   = '0;
        ex_valid_d = 1'b0;
        if (flush) begin
          if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CW'(1);
        end else begin
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CW'(1);
        end
      end else begin
        ex_wb_d    = id_wb;
        ex_m_d     = id_m;
        ex_exe_d   = id_exe;
        ex_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_wb_q     <= '0;
      ex_m_q      <= '0;
      ex_exe_q    <= '0;
      ex_rd1_q    <= '0;
      ex_rd2_q    <= '0;
      ex_imm_q    <= '0;
      ex_pc4_q    <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_wb_q     <= ex_wb_d;
      ex_m_q      <= ex_m_d;
      ex_exe_q    <= ex_exe_d;
      ex_rd1_q    <= ex_rd1_d;
      ex_rd2_q    <= ex_rd2_d;
      ex_imm_q    <= ex_imm_d;
      ex_pc4_q    <= ex_pc4_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rd_q     <= ex_rd_d;
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_wb     = ex_wb_q;
  assign ex_m      = ex_m_q;
  assign ex_exe    = ex_exe_q;
  assign ex_rd1    = ex_rd1_q;
  assign ex_rd2    = ex_rd2_q;
  assign ex_imm    = ex_imm_q;
  assign ex_pc4    = ex_pc4_q;
  assign ex_rs     = ex_rs_q;
  assign ex_rt     = ex_rt_q;
  assign ex_rd     = ex_rd_q;
  assign ex_valid  = ex_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
